// File: rtl/pid_pkg.sv
// Shared types and constants for the PID control-side sequencer.
package pid_pkg;

    localparam int PID_D_WIDTH = 18;

    typedef logic signed [PID_D_WIDTH-1:0] pid_data_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SAMPLE,
        S_ITER,
        S_EMIT
    } state_t;

    // Gain register addresses on the PID write port.
    localparam logic [1:0] KP  = 2'd0;
    localparam logic [1:0] KI  = 2'd1;
    localparam logic [1:0] KD1 = 2'd2;
    localparam logic [1:0] KD2 = 2'd3;

endpackage

// File: rtl/pid_tick_gen.sv
// Sample-period counter: counts 0..P-1 (P = max(period, 2)) and flags the last count.
module pid_tick_gen
    import pid_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 run,
    input  logic [CNT_WIDTH-1:0] period,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] limit;
    logic [CNT_WIDTH-1:0] period_m1;

    always_comb begin
        period_m1 = (period < CNT_WIDTH'(2)) ? CNT_WIDTH'(1) : period - CNT_WIDTH'(1);
    end

    assign tick = run && !clear && (count == limit);

    // The limit is only reloaded at a wrap or while cleared, so a period
    // change never truncates the interval in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            limit <= CNT_WIDTH'(1);
        end else if (clear || tick) begin
            count <= '0;
            limit <= period_m1;
        end else if (run) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pid_sequencer.sv
// Control front end for the PID datapath: gain loading, periodic measurement
// fetch, iterate strobe and result emission with overrun detection.
module pid_sequencer
    import pid_pkg::*;
#(
    parameter int D_WIDTH   = 18,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CNT_WIDTH-1:0]      period,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic signed [D_WIDTH-1:0] cfg_kp,
    input  logic signed [D_WIDTH-1:0] cfg_ki,
    input  logic signed [D_WIDTH-1:0] cfg_kd1,
    input  logic signed [D_WIDTH-1:0] cfg_kd2,
    input  logic signed [D_WIDTH-1:0] target,
    input  logic                      meas_valid,
    output logic                      meas_ready,
    input  logic signed [D_WIDTH-1:0] meas_data,
    output logic                      pid_resetn,
    output logic                      pid_write_enable,
    output logic [D_WIDTH-1:0]        pid_reg_addr,
    output logic signed [D_WIDTH-1:0] pid_reg_data,
    output logic                      pid_iterate_enable,
    output logic signed [D_WIDTH-1:0] pid_target,
    output logic signed [D_WIDTH-1:0] pid_measurement,
    input  logic signed [D_WIDTH-1:0] pid_out,
    output logic                      out_valid,
    output logic signed [D_WIDTH-1:0] out_data,
    output logic                      overrun
);

    state_t                    state;
    state_t                    state_next;
    logic [1:0]                idx;
    logic [1:0]                idx_next;
    logic                      tick;
    logic                      cfg_accept;
    logic                      xfer;
    logic                      overrun_next;
    logic [1:0]                rst_sync;
    logic signed [D_WIDTH-1:0] out_hold;
    logic signed [D_WIDTH-1:0] shadow [4];

    assign cfg_accept = cfg_valid && cfg_ready;
    assign xfer       = meas_valid && meas_ready;

    pid_tick_gen #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == S_IDLE),
        .run    (enable),
        .period (period),
        .tick   (tick)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            S_IDLE: begin
                if (cfg_accept) begin
                    state_next = S_LOAD;
                    idx_next   = 2'd0;
                end else if (enable) begin
                    state_next = S_WAIT;
                end
            end
            S_LOAD: begin
                idx_next = idx + 2'd1;
                if (idx == 2'd3) begin
                    state_next = enable ? S_WAIT : S_IDLE;
                end
            end
            S_WAIT: begin
                if (cfg_accept) begin
                    state_next = S_LOAD;
                    idx_next   = 2'd0;
                end else if (tick) begin
                    state_next = S_SAMPLE;
                end else if (!enable) begin
                    state_next = S_IDLE;
                end
            end
            S_SAMPLE: begin
                if (xfer) begin
                    state_next = S_ITER;
                end else if (!enable) begin
                    state_next = S_IDLE;
                end
            end
            S_ITER:  state_next = S_EMIT;
            S_EMIT:  state_next = enable ? S_WAIT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // A tick is lost whenever it cannot start a sample; a cfg accept clears
    // the flag unless it is itself the reason the tick was lost.
    always_comb begin
        if (cfg_accept) begin
            overrun_next = tick;
        end else begin
            overrun_next = overrun || (tick && (state != S_WAIT));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            idx                <= 2'd0;
            cfg_ready          <= 1'b0;
            meas_ready         <= 1'b0;
            pid_write_enable   <= 1'b1;
            pid_reg_addr       <= '0;
            pid_reg_data       <= '0;
            pid_iterate_enable <= 1'b0;
            pid_target         <= '0;
            pid_measurement    <= '0;
            out_valid          <= 1'b0;
            out_hold           <= '0;
            overrun            <= 1'b0;
        end else begin
            state              <= state_next;
            idx                <= idx_next;
            cfg_ready          <= (state_next == S_IDLE) || (state_next == S_WAIT);
            meas_ready         <= (state_next == S_SAMPLE);
            pid_write_enable   <= (state_next != S_LOAD);
            pid_iterate_enable <= (state_next == S_ITER);
            out_valid          <= (state_next == S_EMIT);
            overrun            <= overrun_next;
            if (state_next == S_LOAD) begin
                pid_reg_addr <= D_WIDTH'(idx_next);
                // The shadow copy is written on this same edge, so the first
                // word comes straight from the config bus.
                pid_reg_data <= cfg_accept ? cfg_kp : shadow[idx_next];
            end else begin
                pid_reg_addr <= '0;
                pid_reg_data <= '0;
            end
            if (xfer) begin
                pid_measurement <= meas_data;
                pid_target      <= target;
            end
            if (state == S_EMIT) begin
                out_hold <= pid_out;
            end
        end
    end

    // NOTE: the shadow gains are storage, not control: they are always
    // written on accept before LOAD reads them, so they carry no reset.
    always_ff @(posedge clock) begin
        if (cfg_accept) begin
            shadow[KP]  <= cfg_kp;
            shadow[KI]  <= cfg_ki;
            shadow[KD1] <= cfg_kd1;
            shadow[KD2] <= cfg_kd2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign pid_resetn = rst_sync[1];

    // The PID result is only valid after the ITER edge, so it is passed
    // through during EMIT and held afterwards.
    assign out_data = out_valid ? pid_out : out_hold;

endmodule

// File: tb/tb_pid_sequencer.sv
// Self-checking bench for pid_sequencer with a behavioural PID and result scoreboard.
`timescale 1ns/1ps
module tb_pid_sequencer;
    import pid_pkg::*;

    localparam int DW = 18;
    localparam int CW = 16;

    typedef struct {
        int        addr;
        pid_data_t data;
    } wr_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic [CW-1:0]   period = 16'd10;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    pid_data_t       cfg_kp = '0, cfg_ki = '0, cfg_kd1 = '0, cfg_kd2 = '0;
    pid_data_t       target = '0;
    logic            meas_valid = 1'b0;
    logic            meas_ready;
    pid_data_t       meas_data = '0;
    logic            pid_resetn;
    logic            pid_write_enable;
    logic [DW-1:0]   pid_reg_addr;
    pid_data_t       pid_reg_data;
    logic            pid_iterate_enable;
    pid_data_t       pid_target, pid_measurement;
    pid_data_t       pid_out = '0;
    logic            out_valid;
    pid_data_t       out_data;
    logic            overrun;

    pid_sequencer #(.D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .period             (period),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .cfg_kp             (cfg_kp),
        .cfg_ki             (cfg_ki),
        .cfg_kd1            (cfg_kd1),
        .cfg_kd2            (cfg_kd2),
        .target             (target),
        .meas_valid         (meas_valid),
        .meas_ready         (meas_ready),
        .meas_data          (meas_data),
        .pid_resetn         (pid_resetn),
        .pid_write_enable   (pid_write_enable),
        .pid_reg_addr       (pid_reg_addr),
        .pid_reg_data       (pid_reg_data),
        .pid_iterate_enable (pid_iterate_enable),
        .pid_target         (pid_target),
        .pid_measurement    (pid_measurement),
        .pid_out            (pid_out),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .overrun            (overrun)
    );

    always #5 clock = ~clock;

    // Behavioural PID: gain registers plus a simple registered result.
    pid_data_t gain [4] = '{default: '0};
    always @(posedge clock) begin
        if (!pid_write_enable) gain[pid_reg_addr[1:0]] <= pid_reg_data;
        if (!pid_resetn) pid_out <= '0;
        else if (pid_iterate_enable) pid_out <= pid_target - pid_measurement + gain[0] + gain[3];
    end

    int        n_checks = 0, n_errors = 0;
    int        cyc = 0, n_iter = 0, n_out = 0, n_xfer = 0, n_wr = 0, last_wr_cyc = 0;
    logic      prev_iter = 1'b0;
    pid_data_t cur_kp = '0, cur_kd2 = '0;
    pid_data_t exp_q [$];
    wr_t       wr_q [$];
    int        iter_q [$];

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t w;
        if (!pid_write_enable) begin
            n_wr++;
            if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                w = wr_q.pop_front();
                check("wr_addr", pid_reg_addr, w.addr);
                check("wr_data", pid_reg_data, w.data);
                check("wr_cfg_ready_low", cfg_ready, 0);
                if (w.addr != 0) check("wr_consecutive", cyc - last_wr_cyc, 1);
            end
            last_wr_cyc = cyc;
        end
        if (pid_iterate_enable) begin
            check("iter_one_cycle", prev_iter, 0);
            n_iter++;
            iter_q.push_back(cyc);
        end
        if (out_valid) begin
            check("out_after_iter", prev_iter, 1);
            n_out++;
            if (exp_q.size() == 0) check("out_unexpected", 1, 0);
            else check("out_data", out_data, exp_q.pop_front());
        end
        prev_iter = pid_iterate_enable;
    endtask

    // One clock: record a handshake that the coming edge will complete,
    // observe outputs at the falling edge, then refresh the data inputs.
    task automatic step(input int n = 1);
        logic [31:0] r;
        pid_data_t   e;
        for (int i = 0; i < n; i++) begin
            if (!reset && meas_valid && meas_ready) begin
                e = target - meas_data + cur_kp + cur_kd2;
                exp_q.push_back(e);
                n_xfer++;
            end
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (!reset) monitor();
            r = $urandom; meas_data = r[DW-1:0];
            r = $urandom; target = r[DW-1:0];
        end
    endtask

    task automatic load_gains(input pid_data_t kp, ki, kd1, kd2);
        int wr0;
        wr0 = n_wr;
        cfg_kp = kp; cfg_ki = ki; cfg_kd1 = kd1; cfg_kd2 = kd2;
        cfg_valid = 1'b1;
        wr_q.push_back('{0, kp}); wr_q.push_back('{1, ki});
        wr_q.push_back('{2, kd1}); wr_q.push_back('{3, kd2});
        check("cfg_ready_idle", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        cur_kp = kp; cur_kd2 = kd2;
        step(6);
        check("wr_all_done", wr_q.size(), 0);
        check("wr_count", n_wr - wr0, 4);
    endtask

    task automatic wait_meas_ready(input string tag);
        for (int i = 0; i < 40 && !meas_ready; i++) step();
        check(tag, meas_ready, 1);
    endtask

    task automatic check_reset_values();
        check("rst_pid_resetn", pid_resetn, 0);
        check("rst_write_enable", pid_write_enable, 1);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_meas_ready", meas_ready, 0);
        check("rst_iterate", pid_iterate_enable, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_reg_data", pid_reg_data, 0);
        check("rst_pid_target", pid_target, 0);
        check("rst_pid_meas", pid_measurement, 0);
        check("rst_out_data", out_data, 0);
    endtask

    initial begin
        int c, it0, x0, o0;

        step(2);
        check_reset_values();
        reset = 1'b0;
        step();
        check("release_resetn_clk1", pid_resetn, 0);
        step();
        check("release_resetn_clk2", pid_resetn, 1);

        // Gain load from IDLE.
        load_gains(18'sd100, 18'sd20, 18'sd5, -18'sd3);

        // Periodic sampling, period 10, measurement always available.
        period = 16'd10; meas_valid = 1'b1; iter_q.delete();
        enable = 1'b1; c = cyc;
        step(55);
        check("periodic_iter_count", iter_q.size(), 5);
        if (iter_q.size() > 0) check("periodic_first_lat", iter_q[0] - c, 12);
        for (int i = 1; i < iter_q.size(); i++) check("periodic_interval", iter_q[i] - iter_q[i-1], 10);
        check("periodic_no_overrun", overrun, 0);
        enable = 1'b0;
        step(10);
        check("periodic_sb_empty", exp_q.size(), 0);
        check("periodic_out_count", n_out, n_iter);

        // Overrun: measurement withheld across several ticks.
        period = 16'd4; meas_valid = 1'b0;
        it0 = n_iter; x0 = n_xfer; o0 = n_out;
        enable = 1'b1;
        wait_meas_ready("ovr_sample_reached");
        step(6);
        meas_valid = 1'b1;
        step(12);
        enable = 1'b0;
        step(8);
        check("ovr_flag", overrun, 1);
        check("ovr_iter_per_xfer", n_iter - it0, n_xfer - x0);
        check("ovr_out_per_iter", n_out - o0, n_iter - it0);
        check("ovr_sb_empty", exp_q.size(), 0);
        load_gains(18'sd7, 18'sd1, 18'sd2, -18'sd9);
        check("ovr_cleared_by_cfg", overrun, 0);

        // Config accept colliding with a tick in WAIT.
        period = 16'd10; meas_valid = 1'b1;
        enable = 1'b1; c = cyc;
        step(10);
        cfg_kp = 18'sd50; cfg_ki = 18'sd4; cfg_kd1 = 18'sd3; cfg_kd2 = 18'sd2;
        cfg_valid = 1'b1;
        wr_q.push_back('{0, cfg_kp}); wr_q.push_back('{1, cfg_ki});
        wr_q.push_back('{2, cfg_kd1}); wr_q.push_back('{3, cfg_kd2});
        check("coll_cfg_ready", cfg_ready, 1);
        it0 = n_iter;
        step();
        cfg_valid = 1'b0;
        cur_kp = 18'sd50; cur_kd2 = 18'sd2;
        check("coll_overrun", overrun, 1);
        check("coll_load_entered", pid_write_enable, 0);
        for (int i = 0; i < 8; i++) begin
            check("coll_no_meas_ready", meas_ready, 0);
            step();
        end
        check("coll_no_iter", n_iter, it0);
        step(12);
        check("coll_resumed_iter", n_iter - it0, 1);
        enable = 1'b0;
        step(8);
        check("coll_wr_done", wr_q.size(), 0);
        check("coll_sb_empty", exp_q.size(), 0);

        // Enable dropped while waiting for a measurement.
        period = 16'd10; meas_valid = 1'b0;
        enable = 1'b1;
        wait_meas_ready("drop_sample_reached");
        it0 = n_iter;
        enable = 1'b0;
        step();
        check("drop_meas_ready_low", meas_ready, 0);
        step(5);
        check("drop_in_idle", cfg_ready, 1);
        check("drop_no_iter", n_iter, it0);
        meas_valid = 1'b1; iter_q.delete();
        enable = 1'b1; c = cyc;
        step(14);
        if (iter_q.size() == 0) check("drop_restart_iter", 0, 1);
        else check("drop_restart_lat", iter_q[0] - c, 12);
        enable = 1'b0;
        step(8);

        // Periods below 2 behave as 2.
        for (int p = 0; p < 2; p++) begin
            period = CW'(p); meas_valid = 1'b1; iter_q.delete();
            enable = 1'b1; c = cyc;
            step(14);
            if (iter_q.size() < 2) check("short_iter_count", iter_q.size(), 3);
            else begin
                check("short_first_lat", iter_q[0] - c, 4);
                check("short_interval", iter_q[1] - iter_q[0], 4);
            end
            check("short_overrun", overrun, 1);
            enable = 1'b0;
            step(8);
            check("short_sb_empty", exp_q.size(), 0);
        end

        // Asynchronous reset in the middle of a run.
        period = 16'd10; meas_valid = 1'b1;
        enable = 1'b1;
        step(13);
        #2 reset = 1'b1;
        #1 check_reset_values();
        exp_q.delete(); wr_q.delete();
        enable = 1'b0;
        step(2);
        reset = 1'b0;
        step();
        check("rerelease_resetn_clk1", pid_resetn, 0);
        step();
        check("rerelease_resetn_clk2", pid_resetn, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
